// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 register file: load extension, writeback mux, two async read ports.
// Optional macro WB_BYPASS_EN enables write-through from ResultW to RD1/RD2.
module wb_regfile #(
    parameter int NREG = 32,
    parameter int W    = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         RegWriteW,
    input  logic [1:0]   MemtoRegW,
    input  logic [1:0]   ext_sh_W,
    input  logic         ext_bh_W,
    input  logic [W-1:0] ReadDataW,
    input  logic [W-1:0] ALU_outW,
    input  logic [W-1:0] PC_8W,
    input  logic [4:0]   WriteRegW,
    input  logic [4:0]   A1,
    input  logic [4:0]   A2,
    output logic [W-1:0] RD1,
    output logic [W-1:0] RD2,
    output logic [W-1:0] ResultW,
    output logic         wb_valid
);

    logic [W-1:0] regFile_r [NREG];
    logic [W-1:0] loadExt_s;

    // Picks the addressed byte/halfword from the aligned word and extends it to W bits.
    function automatic logic [W-1:0] extendLoad(
        input logic [W-1:0] data,
        input logic [1:0]   off,
        input logic [1:0]   size,
        input logic         sgn
    );
        logic [7:0]   byteSel;
        logic [15:0]  halfSel;
        logic [W-1:0] res;
        case (off)
            2'b00:   byteSel = data[7:0];
            2'b01:   byteSel = data[15:8];
            2'b10:   byteSel = data[23:16];
            2'b11:   byteSel = data[31:24];
            default: byteSel = data[7:0];
        endcase
        halfSel = off[1] ? data[31:16] : data[15:0];
        case (size)
            2'b01:   res = {{(W-16){sgn & halfSel[15]}}, halfSel};
            2'b10:   res = {{(W-8){sgn & byteSel[7]}}, byteSel};
            default: res = data;
        endcase
        return res;
    endfunction

    // Writeback source selection; the reserved encoding falls back to the ALU result.
    always_comb begin
        loadExt_s = extendLoad(ReadDataW, ALU_outW[1:0], ext_sh_W, ext_bh_W);
        ResultW   = ALU_outW;
        case (MemtoRegW)
            2'b01:   ResultW = loadExt_s;
            2'b10:   ResultW = PC_8W;
            default: ResultW = ALU_outW;
        endcase
    end

    assign wb_valid = RegWriteW && (WriteRegW != 5'd0);

    // Register storage; r0 is never written because wb_valid excludes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regFile_r[i] <= '0;
            end
        end else if (wb_valid) begin
            regFile_r[WriteRegW] <= ResultW;
        end
    end

    // Read port 1; reset also masks the write-through path so reads stay 0.
    always_comb begin
        RD1 = '0;
        if ((A1 == 5'd0) || !rst_n) begin
            RD1 = '0;
        end
`ifdef WB_BYPASS_EN
        else if (wb_valid && (WriteRegW == A1)) begin
            RD1 = ResultW;
        end
`endif
        else begin
            RD1 = regFile_r[A1];
        end
    end

    // Read port 2, identical structure to port 1.
    always_comb begin
        RD2 = '0;
        if ((A2 == 5'd0) || !rst_n) begin
            RD2 = '0;
        end
`ifdef WB_BYPASS_EN
        else if (wb_valid && (WriteRegW == A2)) begin
            RD2 = ResultW;
        end
`endif
        else begin
            RD2 = regFile_r[A2];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations queued at drive time, popped and asserted at sample time.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic [1:0]  MemtoRegW;
    logic [1:0]  ext_sh_W;
    logic        ext_bh_W;
    logic [31:0] ReadDataW;
    logic [31:0] ALU_outW;
    logic [31:0] PC_8W;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic        wb_valid;

    localparam int SEL_RD1 = 0;
    localparam int SEL_RD2 = 1;
    localparam int SEL_RES = 2;
    localparam int SEL_VLD = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_regfile #(.NREG(32), .W(32)) dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ext_sh_W(ext_sh_W), .ext_bh_W(ext_bh_W), .ReadDataW(ReadDataW),
        .ALU_outW(ALU_outW), .PC_8W(PC_8W), .WriteRegW(WriteRegW),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .ResultW(ResultW), .wb_valid(wb_valid)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RD1: return RD1;
            SEL_RD2: return RD2;
            SEL_RES: return ResultW;
            default: return {31'd0, wb_valid};
        endcase
    endfunction

    task automatic expectVal(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic drainCheck();
        exp_t e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] m2r, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] pc8);
        RegWriteW = we;
        MemtoRegW = m2r;
        WriteRegW = wr;
        ALU_outW  = alu;
        PC_8W     = pc8;
    endtask

    task automatic load(input logic [31:0] data, input logic [31:0] alu,
                        input logic [1:0] sh, input logic bh);
        RegWriteW = 1'b0;
        MemtoRegW = 2'b01;
        ReadDataW = data;
        ALU_outW  = alu;
        ext_sh_W  = sh;
        ext_bh_W  = bh;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
        ext_sh_W = 2'b00; ext_bh_W = 1'b0; ReadDataW = 32'd0;
        A1 = 5'd5; A2 = 5'd31;
        #1;
        expectVal("reset_rd1", SEL_RD1, 32'd0);
        expectVal("reset_rd2", SEL_RD2, 32'd0);
        expectVal("reset_valid", SEL_VLD, 32'd0);
        drainCheck();

        // Write r5, then async reset in mid-cycle must clear it at once.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b00, 5'd5, 32'hDEADBEEF, 32'd0);
        expectVal("wr5_result", SEL_RES, 32'hDEADBEEF);
        expectVal("wr5_valid", SEL_VLD, 32'd1);
        #1 drainCheck();
        @(negedge clk);
        RegWriteW = 1'b0;
        expectVal("rd_r5", SEL_RD1, 32'hDEADBEEF);
        #1 drainCheck();
        #1 rst_n = 1'b0;
        expectVal("async_rst_rd1", SEL_RD1, 32'd0);
        expectVal("rst_result_follows", SEL_RES, 32'hDEADBEEF);
        #1 drainCheck();
        #1 rst_n = 1'b1;

        // Load extension through the writeback mux.
        @(negedge clk);
        load(32'h12F45678, 32'h00000001, 2'b10, 1'b1);
        expectVal("lb_off1_s", SEL_RES, 32'h00000056);
        #1 drainCheck();
        load(32'h12F45678, 32'h00000002, 2'b10, 1'b1);
        expectVal("lb_off2_s", SEL_RES, 32'hFFFFFFF4);
        #1 drainCheck();
        load(32'h12F45678, 32'h00000002, 2'b10, 1'b0);
        expectVal("lb_off2_z", SEL_RES, 32'h000000F4);
        #1 drainCheck();
        load(32'h12F45678, 32'h00000003, 2'b10, 1'b1);
        expectVal("lb_off3_s", SEL_RES, 32'h00000012);
        #1 drainCheck();
        load(32'h80017FFF, 32'h00000002, 2'b01, 1'b0);
        expectVal("lh_off2_z", SEL_RES, 32'h00008001);
        #1 drainCheck();
        load(32'h80017FFF, 32'h00000000, 2'b01, 1'b1);
        expectVal("lh_off0_s", SEL_RES, 32'h00007FFF);
        #1 drainCheck();
        load(32'h80017FFF, 32'h00000003, 2'b01, 1'b1);
        expectVal("lh_off3_s", SEL_RES, 32'hFFFF8001);
        #1 drainCheck();
        load(32'h80017FFF, 32'h00000001, 2'b00, 1'b1);
        expectVal("lw_sign_ignored", SEL_RES, 32'h80017FFF);
        #1 drainCheck();
        load(32'h80017FFF, 32'h00000002, 2'b11, 1'b1);
        expectVal("sh11_as_word", SEL_RES, 32'h80017FFF);
        #1 drainCheck();
        drive(1'b0, 2'b11, 5'd0, 32'h00000ABC, 32'h00000444);
        expectVal("m2r11_alu", SEL_RES, 32'h00000ABC);
        #1 drainCheck();

        // Writes to r0 are discarded.
        @(negedge clk);
        drive(1'b1, 2'b00, 5'd0, 32'h00001234, 32'd0);
        A1 = 5'd0;
        expectVal("r0_valid", SEL_VLD, 32'd0);
        expectVal("r0_rd_same", SEL_RD1, 32'd0);
        #1 drainCheck();
        @(negedge clk);
        RegWriteW = 1'b0;
        expectVal("r0_rd_after", SEL_RD1, 32'd0);
        #1 drainCheck();

        // Same-cycle write/read of r31.
        drive(1'b1, 2'b00, 5'd31, 32'h00001111, 32'd0);
        @(negedge clk);
        drive(1'b1, 2'b10, 5'd31, 32'h0000FFFF, 32'h00003008);
        A2 = 5'd31;
        expectVal("jal_result", SEL_RES, 32'h00003008);
`ifdef WB_BYPASS_EN
        expectVal("r31_same_cycle", SEL_RD2, 32'h00003008);
`else
        expectVal("r31_same_cycle", SEL_RD2, 32'h00001111);
`endif
        #1 drainCheck();
        @(negedge clk);
        RegWriteW = 1'b0;
        expectVal("r31_next_cycle", SEL_RD2, 32'h00003008);
        #1 drainCheck();

        // Back-to-back writes to r8.
        A1 = 5'd8;
        drive(1'b1, 2'b00, 5'd8, 32'd1, 32'd0);
        @(negedge clk);
        drive(1'b1, 2'b00, 5'd8, 32'd2, 32'd0);
`ifdef WB_BYPASS_EN
        expectVal("r8_second_cycle", SEL_RD1, 32'd2);
`else
        expectVal("r8_second_cycle", SEL_RD1, 32'd1);
`endif
        #1 drainCheck();
        @(negedge clk);
        drive(1'b0, 2'b00, 5'd8, 32'd99, 32'd0);
        expectVal("r8_last_wins", SEL_RD1, 32'd2);
        #1 drainCheck();
        @(negedge clk);
        expectVal("r8_hold", SEL_RD1, 32'd2);
        expectVal("r31_kept", SEL_RD2, 32'h00003008);
        #1 drainCheck();

        // Reset asserted during a pending write wins.
        @(negedge clk);
        drive(1'b1, 2'b00, 5'd9, 32'h00000055, 32'd0);
        A1 = 5'd9;
        expectVal("pend_result", SEL_RES, 32'h00000055);
        expectVal("pend_valid", SEL_VLD, 32'd1);
        #1 drainCheck();
        #1 rst_n = 1'b0;
        expectVal("pend_rst_rd1", SEL_RD1, 32'd0);
        #1 drainCheck();
        @(negedge clk);
        rst_n = 1'b1;
        RegWriteW = 1'b0;
        expectVal("pend_r9_zero", SEL_RD1, 32'd0);
        expectVal("pend_r31_zero", SEL_RD2, 32'd0);
        #1 drainCheck();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and general-purpose register file of the five-stage MIPS pipeline. The block sits directly downstream of the MEM/WB pipeline register and consumes its W-stage outputs. It selects the writeback value from the ALU result, the extended load data, or PC+8, and writes that value into a 32×32 register file. It also serves the two combinational read ports used by the decode stage.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; register 0 is hardwired to zero.
- `W`, 32: datapath width.

Ports:
- `clk`  in  1: pipeline clock, rising-edge active.
- `rst_n`  in  1: asynchronous active-low reset.
- `RegWriteW`  in  1: write enable for the instruction in W.
- `MemtoRegW`  in  2: writeback source select.
  - 00 = `ALU_outW`.
  - 01 = extended `ReadDataW`.
  - 10 = `PC_8W`.
  - 11 = reserved; treated as 00.
- `ext_sh_W`  in  2: load size.
  - 00 = word.
  - 01 = halfword.
  - 10 = byte.
  - 11 = treated as word.
- `ext_bh_W`  in  1: 1 = sign-extend, 0 = zero-extend; sub-word loads only.
- `ReadDataW`  in  32: raw aligned word from data memory.
- `ALU_outW`  in  32: ALU result; bits [1:0] give the load byte offset.
- `PC_8W`  in  32: link address.
- `WriteRegW`  in  5: destination register.
- `A1`, `A2`  in  5 each: read addresses, driven from the D stage.
- `RD1`, `RD2`  out  32 each: read data.
- `ResultW`  out  32: final writeback value, exported for the forwarding muxes.
- `wb_valid`  out  1: high when `RegWriteW` is 1 and `WriteRegW` is not 0.

## Operation
- Load extension, with offset `off = ALU_outW[1:0]`:
  - Byte: selects `ReadDataW[8*off+7 : 8*off]`.
  - Halfword: selects `ReadDataW[16*off[1]+15 : 16*off[1]]`. `off[0]` is ignored; misalignment is detected upstream.
  - The selected field is extended to 32 bits according to `ext_bh_W`.
  - Word: passes `ReadDataW` unchanged, regardless of `ext_bh_W`.
- `ResultW` is the `MemtoRegW` selection. It is purely combinational.
- Register write:
  - On the rising edge of `clk`, if `wb_valid` is 1, `reg[WriteRegW]` takes `ResultW`.
  - A write to register 0 is discarded; register 0 always reads 0.
- Reads:
  - `RDn` is a combinational read of `reg[An]`.
  - `An` = 0 always yields 0.
  - Bypass applies as described under Configuration.
- Reset:
  - While `rst_n` = 0, every register is cleared to 0 immediately, without waiting for a clock edge.
  - `RD1` and `RD2` therefore read 0. `ResultW` and `wb_valid` still follow their inputs.
  - Deassertion is synchronised upstream; the block needs no internal state machine beyond register storage.

## Timing
- Write latency: a value presented in cycle N is stored at the rising edge ending cycle N. Without bypass it is readable in cycle N+1.
- `ResultW` and `wb_valid` have zero-cycle latency from their inputs.
- Simultaneous write and read of the same register in one cycle: the read returns the new value with bypass enabled, and the old value without it.
- If reset asserts in the same cycle as a pending write, reset wins and the register holds 0.
- Two consecutive writes to the same register: the last one wins. There are no read-modify-write hazards internally.

## Configuration
- Macro `WB_BYPASS_EN`.
- Defined:
  - `RDn` equals `ResultW` when `wb_valid` is 1, `WriteRegW` equals `An`, and `An` is not 0.
  - This is an internal write-through path, so the hazard unit needs no W-to-D forwarding path.
- Undefined:
  - `RDn` always reflects stored contents.
  - The hazard unit must forward `ResultW` to D itself, or stall.

## Test plan
- Reset clears all registers:
  - Write 0xDEADBEEF to r5.
  - Pulse `rst_n` low mid-cycle, asynchronously.
  - `RD1` with `A1`=5 reads 0 immediately.
- Load byte, sign-extended:
  - Inputs: `ReadDataW`=0x12F4_5678, `ALU_outW`=…1 (offset 1), `ext_sh_W`=10, `ext_bh_W`=1, `MemtoRegW`=01.
  - Required: `ResultW`=0x0000_0056.
  - With offset 2 and `ReadDataW`=0x12F4_5678, `ResultW`=0xFFFF_FFF4.
- Load halfword, zero-extended:
  - `ReadDataW`=0x8001_7FFF at offset 2 gives 0x0000_8001.
  - The same data at offset 0 with sign extension gives 0x0000_7FFF.
- Writes to r0 are ignored:
  - `RegWriteW`=1, `WriteRegW`=0, `ALU_outW`=0x1234.
  - Required: `wb_valid`=0, and `RD1` with `A1`=0 reads 0.
- Same-cycle write and read:
  - Write `PC_8W`=0x0000_3008 to r31 (`MemtoRegW`=10) while `A2`=31.
  - With `WB_BYPASS_EN` defined: `RD2`=0x3008 in that cycle.
  - With it undefined: `RD2` shows the old value, then 0x3008 in the next cycle.
- Back-to-back writes:
  - Write r8 with 1, then 2, in consecutive cycles.
  - `RD1` with `A1`=8 reads 2 after the second edge.
  - `RegWriteW`=0 in the next cycle leaves r8 unchanged.
